// File: rtl/y64_rbank_pkg.sv
// Shared types and default sizes for the register-bank scheduler.
package y64_rbank_pkg;

    localparam int REG_W_DEF        = 64;
    localparam int SEL_W_DEF        = 5;
    localparam int WB_BURST_MAX_DEF = 4;

    // Burst counter width; covers WB_BURST_MAX up to 15.
    localparam int BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        DONE = 2'd3
    } rbank_sched_state_t;

endpackage

// File: rtl/rbank_sched.sv
// Time-multiplexes the single select/write port of the 32 x 64 register bank
// between operand fetches (two reads) and writebacks (one write), with a
// bounded writeback burst so a pending fetch is never starved.
module rbank_sched
    import y64_rbank_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int SEL_W        = SEL_W_DEF,
    parameter int WB_BURST_MAX = WB_BURST_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_src_a,
    input  logic [SEL_W-1:0] req_src_b,
    output logic             opr_valid,
    input  logic             opr_ready,
    output logic [REG_W-1:0] opr_a,
    output logic [REG_W-1:0] opr_b,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [SEL_W-1:0] wb_sel,
    input  logic [REG_W-1:0] wb_data,
    output logic             rb_we,
    output logic [SEL_W-1:0] rb_sel,
    output logic [REG_W-1:0] rb_in,
    input  logic [REG_W-1:0] rb_out
);

    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(WB_BURST_MAX);

    rbank_sched_state_t state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [SEL_W-1:0]   src_a_q, src_a_d;
    logic [SEL_W-1:0]   src_b_q, src_b_d;
    logic [REG_W-1:0]   opr_a_q, opr_a_d;
    logic [REG_W-1:0]   opr_b_q, opr_b_d;
    logic               wb_grant;

    // Next-state, port mux and handshakes; everything is held at zero while reset is high.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        state_d   = state_q;
        burst_d   = burst_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        opr_a_d   = opr_a_q;
        opr_b_d   = opr_b_q;
        wb_grant  = 1'b0;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        opr_valid = 1'b0;
        rb_we     = 1'b0;
        rb_sel    = '0;
        rb_in     = '0;

        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    // Writebacks win until the burst limit is hit while a fetch waits.
                    wb_grant = wb_valid && (!req_valid || (burst_q < BURST_LIM));
                    if (wb_grant) begin
                        rb_we    = 1'b1;
                        rb_sel   = wb_sel;
                        rb_in    = wb_data;
                        wb_ready = 1'b1;
                        if (!req_valid) begin
                            burst_d = '0;
                        end else if (burst_q != BURST_LIM) begin
                            burst_d = burst_q + 1'b1;
                        end
                    end else if (req_valid) begin
                        req_ready = 1'b1;
                        src_a_d   = req_src_a;
                        src_b_d   = req_src_b;
                        burst_d   = '0;
                        state_d   = RD_A;
                    end else begin
                        burst_d = '0;
                    end
                end

                RD_A: begin
                    rb_sel  = src_a_q;
                    opr_a_d = rb_out;
                    if (src_a_q == src_b_q) begin
                        // Same register twice: one read serves both operands.
                        opr_b_d = rb_out;
                        state_d = DONE;
                    end else begin
                        state_d = RD_B;
                    end
                end

                RD_B: begin
                    rb_sel  = src_b_q;
                    opr_b_d = rb_out;
                    state_d = DONE;
                end

                DONE: begin
                    // Operands held until consumed; the port stays idle and writebacks wait.
                    opr_valid = 1'b1;
                    if (opr_ready) begin
                        state_d = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // State, burst counter, captured selects and operand registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            opr_a_q <= '0;
            opr_b_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            opr_a_q <= opr_a_d;
            opr_b_q <= opr_b_d;
        end
    end

    assign opr_a = opr_a_q;
    assign opr_b = opr_b_q;

endmodule
